// File: rtl/ddr_arbiter_if.sv
// Burst-capable Avalon-MM style DDR link, used both for requester ports and for the DDR-side port.
// master/slave form the requester handshake; ddr_host/ddr_mem form the memory side, which has no burst_done.
interface ddr_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
);
  logic                    rd;
  logic                    wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [BURST_WIDTH-1:0]  burst_length;
  logic [DATA_WIDTH/8-1:0] mask;
  logic [DATA_WIDTH-1:0]   din;
  logic                    wait_req;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    burst_done;

  modport master   (output rd, wr, addr, burst_length, mask, din,
                    input  wait_req, valid, dout, burst_done);
  modport slave    (input  rd, wr, addr, burst_length, mask, din,
                    output wait_req, valid, dout, burst_done);
  modport ddr_host (output rd, wr, addr, burst_length, mask, din,
                    input  wait_req, valid, dout);
  modport ddr_mem  (input  rd, wr, addr, burst_length, mask, din,
                    output wait_req, valid, dout);
endinterface

// File: rtl/ddr_arbiter.sv
// Two-port DDR3 burst arbiter: one grant per burst, held until the burst's last beat completes.
// Define DDR_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise port 0 has priority.
module ddr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  ddr_arbiter_if.slave    in0,
  ddr_arbiter_if.slave    in1,
  ddr_arbiter_if.ddr_host ddr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam int CW = BURST_WIDTH + 1;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d, target_q, target_d, cnt_inc;
  logic                    req0, req1, win, win_rd;
  logic [BURST_WIDTH-1:0]  win_len;
  logic                    sel_rd, sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [BURST_WIDTH-1:0]  sel_len;
  logic [DATA_WIDTH/8-1:0] sel_mask;
  logic [DATA_WIDTH-1:0]   sel_din;
  logic                    out_rd, out_wr, g_wait, g_valid, g_done;
`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic                    last_q, last_d;
`endif

  assign req0 = in0.rd | in0.wr;
  assign req1 = in1.rd | in1.wr;
`ifdef DDR_ARB_ROUND_ROBIN_EN
  assign win = (req0 & req1) ? ~last_q : req1;
`else
  assign win = req1 & ~req0;
`endif
  assign win_rd  = win ? in1.rd : in0.rd;
  assign win_len = win ? in1.burst_length : in0.burst_length;

  assign sel_rd   = grant_q ? in1.rd           : in0.rd;
  assign sel_wr   = grant_q ? in1.wr           : in0.wr;
  assign sel_addr = grant_q ? in1.addr         : in0.addr;
  assign sel_len  = grant_q ? in1.burst_length : in0.burst_length;
  assign sel_mask = grant_q ? in1.mask         : in0.mask;
  assign sel_din  = grant_q ? in1.din          : in0.din;
  assign cnt_inc  = cnt_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      target_q <= '0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    target_d = target_q;
`ifdef DDR_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    out_rd   = 1'b0;
    out_wr   = 1'b0;
    g_wait   = 1'b1;
    g_valid  = 1'b0;
    g_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d  = win;
          acc_d    = 1'b0;
          cnt_d    = '0;
          target_d = (win_len == '0) ? CW'(1) : {1'b0, win_len};
          state_d  = win_rd ? READ : WRITE;
`ifdef DDR_ARB_ROUND_ROBIN_EN
          last_d   = win;
`endif
        end
      end
      READ: begin
        // Only one read command per burst: once accepted, rd is masked until the burst drains.
        out_rd = sel_rd & ~acc_q;
        g_wait = ddr.wait_req;
        if (out_rd & ~ddr.wait_req) acc_d = 1'b1;
        if (acc_q & ddr.valid) begin
          g_valid = 1'b1;
          if (cnt_inc == target_q) begin
            g_done  = 1'b1;
            cnt_d   = '0;
            acc_d   = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WRITE: begin
        out_wr = sel_wr;
        g_wait = ddr.wait_req;
        if (sel_wr & ~ddr.wait_req) begin
          if (cnt_inc == target_q) begin
            g_done  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ddr.rd           = out_rd;
  assign ddr.wr           = out_wr;
  assign ddr.addr         = sel_addr;
  assign ddr.burst_length = sel_len;
  assign ddr.mask         = sel_mask;
  assign ddr.din          = sel_din;

  assign in0.wait_req   = grant_q ? 1'b1 : g_wait;
  assign in1.wait_req   = grant_q ? g_wait : 1'b1;
  assign in0.valid      = ~grant_q & g_valid;
  assign in1.valid      = grant_q & g_valid;
  assign in0.burst_done = ~grant_q & g_done;
  assign in1.burst_done = grant_q & g_done;
  assign in0.dout       = ddr.dout;
  assign in1.dout       = ddr.dout;
endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: directed scenarios plus randomized bursts against a
// transaction-level model (which port wins, how many beats, when the burst ends).
module tb_ddr_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ddr_arbiter_if i0();
  ddr_arbiter_if i1();
  ddr_arbiter_if d();

  ddr_arbiter dut (.clock(clock), .reset(reset), .in0(i0), .in1(i1), .ddr(d));

  int n_tests = 0;
  int n_fail  = 0;

  bit          pend [2];
  bit          p_rd [2];
  bit          p_wr [2];
  logic [31:0] p_addr [2];
  logic [7:0]  p_len [2];
`ifdef DDR_ARB_ROUND_ROBIN_EN
  bit          m_last = 1'b1;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic wait_of(input int p);
    return (p == 0) ? i0.wait_req : i1.wait_req;
  endfunction
  function automatic logic valid_of(input int p);
    return (p == 0) ? i0.valid : i1.valid;
  endfunction
  function automatic logic done_of(input int p);
    return (p == 0) ? i0.burst_done : i1.burst_done;
  endfunction
  function automatic logic [63:0] dout_of(input int p);
    return (p == 0) ? i0.dout : i1.dout;
  endfunction
  function automatic logic [63:0] din_of(input int p);
    return (p == 0) ? i0.din : i1.din;
  endfunction
  function automatic logic [7:0] mask_of(input int p);
    return (p == 0) ? i0.mask : i1.mask;
  endfunction
  function automatic logic wr_of(input int p);
    return (p == 0) ? i0.wr : i1.wr;
  endfunction

  task automatic set_port(input int p, input logic rd, input logic wr);
    if (p == 0) begin
      i0.rd = rd; i0.wr = wr; i0.addr = p_addr[0]; i0.burst_length = p_len[0];
      i0.din = {$urandom, $urandom}; i0.mask = 8'($urandom);
    end else begin
      i1.rd = rd; i1.wr = wr; i1.addr = p_addr[1]; i1.burst_length = p_len[1];
      i1.din = {$urandom, $urandom}; i1.mask = 8'($urandom);
    end
  endtask

  task automatic drive_req();
    for (int p = 0; p < 2; p++) set_port(p, pend[p] && p_rd[p], pend[p] && p_wr[p]);
  endtask

  // kind: 0 = read, 1 = write, 2 = read and write together (read must win)
  task automatic make_req(input int p, input int kind, input logic [31:0] addr, input logic [7:0] len);
    pend[p]   = 1'b1;
    p_rd[p]   = (kind != 1);
    p_wr[p]   = (kind != 0);
    p_addr[p] = addr;
    p_len[p]  = len;
  endtask

  function automatic int predict_winner();
    if (pend[0] && pend[1]) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
      return m_last ? 0 : 1;
`else
      return 0;
`endif
    end
    return pend[0] ? 0 : 1;
  endfunction

  // Starts in IDLE at edge+1; serves exactly one burst and returns at edge+1 back in IDLE.
  task automatic do_round(input bit spurious, output int won);
    int w, l, tgt, beats, budget;
    bit is_rd, accepted, exp_valid, exp_done, beat;
    drive_req();
    d.wait_req = 1'b0;
    d.valid    = spurious;
    d.dout     = {$urandom, $urandom};
    #3;
    chk("idle_wait0", 64'(i0.wait_req), 64'(1));
    chk("idle_wait1", 64'(i1.wait_req), 64'(1));
    chk("idle_rd", 64'(d.rd), 64'(0));
    chk("idle_wr", 64'(d.wr), 64'(0));
    chk("idle_valid", 64'({i0.valid, i1.valid}), 64'(0));
    chk("idle_done", 64'({i0.burst_done, i1.burst_done}), 64'(0));
    w = predict_winner();
    l = 1 - w;
    won = w;
`ifdef DDR_ARB_ROUND_ROBIN_EN
    m_last = (w == 1);
`endif
    is_rd    = p_rd[w];
    tgt      = (p_len[w] == 8'd0) ? 1 : int'(p_len[w]);
    beats    = 0;
    accepted = 1'b0;
    budget   = 0;
    step();
    d.valid = 1'b0;
    while (beats < tgt && budget < 8 * tgt + 40) begin
      budget++;
      d.wait_req = ($urandom_range(0, 3) == 0);
      if (is_rd) begin
        d.valid = accepted ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
        d.dout  = {$urandom, $urandom};
      end else begin
        d.valid = 1'b0;
        set_port(w, 1'b0, ($urandom_range(0, 4) != 0));
      end
      #3;
      chk("loser_wait", 64'(wait_of(l)), 64'(1));
      chk("loser_valid", 64'(valid_of(l)), 64'(0));
      chk("loser_done", 64'(done_of(l)), 64'(0));
      chk("grant_wait", 64'(wait_of(w)), 64'(d.wait_req));
      chk("out_addr", 64'(d.addr), 64'(p_addr[w]));
      chk("out_len", 64'(d.burst_length), 64'(p_len[w]));
      if (is_rd) begin
        exp_valid = accepted && d.valid;
        exp_done  = exp_valid && (beats + 1 == tgt);
        chk("out_rd", 64'(d.rd), 64'(!accepted));
        chk("out_wr_in_read", 64'(d.wr), 64'(0));
        chk("grant_valid", 64'(valid_of(w)), 64'(exp_valid));
        chk("dout_bcast", dout_of(l), d.dout);
        chk("rd_done", 64'(done_of(w)), 64'(exp_done));
        if (exp_valid) beats++;
        if (!accepted && !d.wait_req) accepted = 1'b1;
      end else begin
        beat     = wr_of(w) && !d.wait_req;
        exp_done = beat && (beats + 1 == tgt);
        chk("out_wr", 64'(d.wr), 64'(wr_of(w)));
        chk("out_rd_in_write", 64'(d.rd), 64'(0));
        chk("out_din", d.din, din_of(w));
        chk("out_mask", 64'(d.mask), 64'(mask_of(w)));
        chk("grant_valid_wr", 64'(valid_of(w)), 64'(0));
        chk("wr_done", 64'(done_of(w)), 64'(exp_done));
        if (beat) beats++;
      end
      step();
      if (is_rd && accepted) set_port(w, 1'b0, 1'b0);
    end
    chk("burst_beats", 64'(beats), 64'(tgt));
    pend[w] = 1'b0;
    set_port(w, 1'b0, 1'b0);
    d.valid    = 1'b0;
    d.wait_req = 1'b0;
  endtask

  initial begin
    int w;
    pend[0] = 1'b0; pend[1] = 1'b0;
    p_addr[0] = '0; p_addr[1] = '0; p_len[0] = '0; p_len[1] = '0;
    set_port(0, 1'b0, 1'b0);
    set_port(1, 1'b0, 1'b0);
    d.wait_req = 1'b0; d.valid = 1'b0; d.dout = '0; d.burst_done = 1'b0;

    step();
    #3;
    chk("rst_wait0", 64'(i0.wait_req), 64'(1));
    chk("rst_wait1", 64'(i1.wait_req), 64'(1));
    chk("rst_rdwr", 64'({d.rd, d.wr}), 64'(0));
    chk("rst_valid", 64'({i0.valid, i1.valid}), 64'(0));
    chk("rst_done", 64'({i0.burst_done, i1.burst_done}), 64'(0));
    step();
    reset = 1'b0;

    // Port 0 read, 4 beats
    make_req(0, 0, 32'h0000_1000, 8'd4);
    do_round(1'b0, w);
    chk("p0_rd_winner", 64'(w), 64'(0));
    // Port 1 write, 8 beats with BUSY stalls
    make_req(1, 1, 32'h0000_4000, 8'd8);
    do_round(1'b0, w);
    chk("p1_wr_winner", 64'(w), 64'(1));

    // Both ports reading length 2, re-requesting immediately
    make_req(0, 0, 32'h0000_0100, 8'd2);
    make_req(1, 0, 32'h0000_0200, 8'd2);
    for (int k = 0; k < 4; k++) begin
      do_round(1'b0, w);
      if (k < 3) make_req(w, 0, (w == 0) ? 32'h0000_0100 : 32'h0000_0200, 8'd2);
    end
    for (int k = 0; k < 2 && (pend[0] || pend[1]); k++) do_round(1'b0, w);

    // Zero burst length is a single beat; spurious valid in IDLE
    make_req(0, 0, 32'h0000_3000, 8'd0);
    do_round(1'b1, w);
    // Maximum burst length, no counter wrap
    make_req(0, 1, 32'h0000_8000, 8'd255);
    do_round(1'b0, w);
    // Read and write together: read wins
    make_req(1, 2, 32'h0000_9000, 8'd3);
    do_round(1'b0, w);

    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1)
          make_req(p, int'($urandom_range(0, 2)), 32'($urandom), 8'($urandom_range(0, 6)));
      if (!pend[0] && !pend[1])
        make_req(r % 2, int'($urandom_range(0, 2)), 32'($urandom), 8'($urandom_range(0, 6)));
      do_round($urandom_range(0, 2) == 0, w);
    end
    for (int k = 0; k < 2 && (pend[0] || pend[1]); k++) do_round(1'b0, w);

    // Reset during beat 3 of an 8-beat write
    make_req(1, 1, 32'h0000_A000, 8'd8);
    drive_req();
    d.wait_req = 1'b0;
    d.valid    = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("pre_rst_wr", 64'(d.wr), 64'(1));
      step();
    end
    #2;
    chk("beat3_wr", 64'(d.wr), 64'(1));
    reset = 1'b1;
    #1;
    chk("async_rst_wr", 64'(d.wr), 64'(0));
    chk("async_rst_wait0", 64'(i0.wait_req), 64'(1));
    chk("async_rst_wait1", 64'(i1.wait_req), 64'(1));
    chk("async_rst_done", 64'(i1.burst_done), 64'(0));
    pend[1] = 1'b0;
    set_port(1, 1'b0, 1'b0);
    step();
    reset = 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
    m_last = 1'b1;
`endif
    make_req(0, 0, 32'h0000_B000, 8'd2);
    make_req(1, 1, 32'h0000_C000, 8'd3);
    do_round(1'b0, w);
    chk("post_rst_winner", 64'(w), 64'(0));
    do_round(1'b0, w);
    chk("post_rst_second", 64'(w), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
